// File: rtl/avmm_wr_ack_pkg.sv
// rtl/avmm_wr_ack_pkg.sv - shared constants and FSM types for the multi-channel write-ack expander
package avmm_wr_ack_pkg;

  localparam int ERR_OVF       = 0;
  localparam int ERR_UNEXP_ACK = 1;
  localparam int ERR_ZERO_BC   = 2;
  localparam int ERR_W         = 3;
  localparam int STATS_W       = 32;

  typedef enum logic {
    TRK_IDLE,
    TRK_IN_BURST
  } trk_state_t;

  typedef enum logic {
    EXP_IDLE,
    EXP_RUN
  } exp_state_t;

endpackage

// File: rtl/avmm_wr_ack_expander_mc_if.sv
// rtl/avmm_wr_ack_expander_mc_if.sv - per-channel write observation, burst ack and word ack bundle
interface avmm_wr_ack_expander_mc_if #(
  parameter int NUM_CH     = 4,
  parameter int BURSTCNT_W = 7,
  parameter int DEPTH      = 64
);
  import avmm_wr_ack_pkg::*;

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [NUM_CH-1:0]            kernel_avmm_wr;
  logic [NUM_CH-1:0]            kernel_avmm_waitreq;
  logic [NUM_CH*BURSTCNT_W-1:0] kernel_avmm_burstcnt;
  logic [NUM_CH-1:0]            burst_ack;
  logic [NUM_CH-1:0]            word_ack;
  logic [NUM_CH-1:0]            wr_stall;
  logic [NUM_CH*CNT_W-1:0]      outstanding_bursts;
  logic [NUM_CH*ERR_W-1:0]      err_flags;
  logic [NUM_CH*STATS_W-1:0]    stats_words;

  modport master (
    output kernel_avmm_wr, kernel_avmm_waitreq, kernel_avmm_burstcnt, burst_ack,
    input  word_ack, wr_stall, outstanding_bursts, err_flags, stats_words
  );

  modport slave (
    input  kernel_avmm_wr, kernel_avmm_waitreq, kernel_avmm_burstcnt, burst_ack,
    output word_ack, wr_stall, outstanding_bursts, err_flags, stats_words
  );

endinterface

// File: rtl/avmm_wr_ack_chan.sv
// rtl/avmm_wr_ack_chan.sv - one channel: burst tracker, burstcount FIFO, pending acks, word expander.
// Optional acked-word statistics under AVMM_WR_ACK_MC_STATS_EN.
module avmm_wr_ack_chan
  import avmm_wr_ack_pkg::*;
#(
  parameter int  BURSTCNT_W = 7,
  parameter int  DEPTH      = 64,
  localparam int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic                  waitreq,
  input  logic [BURSTCNT_W-1:0] burstcnt,
  input  logic                  burst_ack,
  output logic                  word_ack,
  output logic                  wr_stall,
  output logic [CNT_W-1:0]      outstanding,
  output logic [ERR_W-1:0]      err,
  output logic [STATS_W-1:0]    stats_words
);

  localparam int PTR_W = $clog2(DEPTH);

  trk_state_t            trk_state, trk_next;
  exp_state_t            exp_state, exp_next;
  logic [BURSTCNT_W-1:0] beats_left, beats_left_next;
  logic [BURSTCNT_W-1:0] words_left, words_left_next;
  logic [BURSTCNT_W-1:0] mem [DEPTH];
  logic [BURSTCNT_W-1:0] head;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count, pending, pend_next;
  logic [CNT_W:0]        count_nx_w, pend_raw;
  logic                  beat, full, enq, pop, pop_ok, unexp;
  logic [ERR_W-1:0]      err_set;

  assign beat        = wr & ~waitreq;
  assign full        = (count == CNT_W'(DEPTH));
  assign wr_stall    = full;
  assign outstanding = count;
  assign head        = mem[rd_ptr];

  always_comb begin
    trk_next        = trk_state;
    beats_left_next = beats_left;
    enq             = 1'b0;
    err_set         = '0;
    if (beat) begin
      case (trk_state)
        TRK_IDLE: begin
          if (burstcnt == '0) begin
            err_set[ERR_ZERO_BC] = 1'b1;
          end else begin
            enq                  = ~full;
            err_set[ERR_OVF]     = full;
            // A dropped burst still has its tail beats tracked.
            if (burstcnt != BURSTCNT_W'(1)) begin
              beats_left_next = burstcnt - BURSTCNT_W'(1);
              trk_next        = TRK_IN_BURST;
            end
          end
        end
        TRK_IN_BURST: begin
          beats_left_next = beats_left - BURSTCNT_W'(1);
          if (beats_left == BURSTCNT_W'(1)) begin
            trk_next = TRK_IDLE;
          end
        end
        default: trk_next = TRK_IDLE;
      endcase
    end
    err_set[ERR_UNEXP_ACK] = unexp;
  end

  // An ack arriving this cycle may start the pop directly, giving one-cycle ack-to-word latency.
  assign pop_ok = ((pending != '0) || burst_ack) && (count != '0);

  always_comb begin
    exp_next        = exp_state;
    words_left_next = words_left;
    pop             = 1'b0;
    word_ack        = 1'b0;
    case (exp_state)
      EXP_IDLE: begin
        if (pop_ok) begin
          pop             = 1'b1;
          words_left_next = head;
          exp_next        = EXP_RUN;
        end
      end
      EXP_RUN: begin
        word_ack = 1'b1;
        if (words_left == BURSTCNT_W'(1)) begin
          if (pop_ok) begin
            pop             = 1'b1;
            words_left_next = head;
          end else begin
            words_left_next = '0;
            exp_next        = EXP_IDLE;
          end
        end else begin
          words_left_next = words_left - BURSTCNT_W'(1);
        end
      end
      default: exp_next = EXP_IDLE;
    endcase
  end

  always_comb begin
    count_nx_w = {1'b0, count} + (CNT_W+1)'(enq) - (CNT_W+1)'(pop);
    pend_raw   = {1'b0, pending} + (CNT_W+1)'(burst_ack) - (CNT_W+1)'(pop);
    unexp      = burst_ack && (pend_raw > count_nx_w);
    pend_next  = unexp ? (pending - CNT_W'(pop)) : pend_raw[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      mem[wr_ptr] <= burstcnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trk_state  <= TRK_IDLE;
      exp_state  <= EXP_IDLE;
      beats_left <= '0;
      words_left <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      pending    <= '0;
      err        <= '0;
    end else begin
      trk_state  <= trk_next;
      exp_state  <= exp_next;
      beats_left <= beats_left_next;
      words_left <= words_left_next;
      wr_ptr     <= wr_ptr + PTR_W'(enq);
      rd_ptr     <= rd_ptr + PTR_W'(pop);
      count      <= count_nx_w[CNT_W-1:0];
      pending    <= pend_next;
      err        <= err | err_set;
    end
  end

`ifdef AVMM_WR_ACK_MC_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stats_words <= '0;
    end else if (word_ack && (stats_words != '1)) begin
      stats_words <= stats_words + STATS_W'(1);
    end
  end
`else
  assign stats_words = '0;
`endif

endmodule

// File: rtl/avmm_wr_ack_expander_mc.sv
// rtl/avmm_wr_ack_expander_mc.sv - NUM_CH independent per-burst to per-word write-ack expanders.
// Statistics counters enabled by AVMM_WR_ACK_MC_STATS_EN.
module avmm_wr_ack_expander_mc
  import avmm_wr_ack_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int BURSTCNT_W = 7,
  parameter int DEPTH      = 64
) (
  input logic                         kernel_avmm_clk,
  input logic                         kernel_avmm_reset,
  avmm_wr_ack_expander_mc_if.slave    bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [1:0] rst_pipe;
  logic       rst_sync;

  // Assert immediately, release two clocks after the external reset drops.
  always_ff @(posedge kernel_avmm_clk or posedge kernel_avmm_reset) begin
    if (kernel_avmm_reset) begin
      rst_pipe <= 2'b11;
    end else begin
      rst_pipe <= {rst_pipe[0], 1'b0};
    end
  end

  assign rst_sync = rst_pipe[1];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
    avmm_wr_ack_chan #(
      .BURSTCNT_W (BURSTCNT_W),
      .DEPTH      (DEPTH)
    ) u_chan (
      .clk         (kernel_avmm_clk),
      .rst         (rst_sync),
      .wr          (bus.kernel_avmm_wr[c]),
      .waitreq     (bus.kernel_avmm_waitreq[c]),
      .burstcnt    (bus.kernel_avmm_burstcnt[c*BURSTCNT_W +: BURSTCNT_W]),
      .burst_ack   (bus.burst_ack[c]),
      .word_ack    (bus.word_ack[c]),
      .wr_stall    (bus.wr_stall[c]),
      .outstanding (bus.outstanding_bursts[c*CNT_W +: CNT_W]),
      .err         (bus.err_flags[c*ERR_W +: ERR_W]),
      .stats_words (bus.stats_words[c*STATS_W +: STATS_W])
    );
  end

endmodule

// File: tb/tb_avmm_wr_ack_expander_mc.sv
// tb/tb_avmm_wr_ack_expander_mc.sv - randomized and directed bench against a queue-based ack model
module tb_avmm_wr_ack_expander_mc;
  import avmm_wr_ack_pkg::*;

  localparam int NUM_CH = 4;
  localparam int BW     = 7;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  avmm_wr_ack_expander_mc_if #(.NUM_CH(NUM_CH), .BURSTCNT_W(BW), .DEPTH(DEPTH)) bus ();

  avmm_wr_ack_expander_mc #(.NUM_CH(NUM_CH), .BURSTCNT_W(BW), .DEPTH(DEPTH)) dut (
    .kernel_avmm_clk   (clk),
    .kernel_avmm_reset (rst),
    .bus               (bus)
  );

  // Model: queued burst sizes, acked-not-started bursts, words left in the current expansion,
  // beats left in the burst being written.
  int         bq [NUM_CH][$];
  int         pend [NUM_CH];
  int         cur [NUM_CH];
  int         left [NUM_CH];
  logic [2:0] m_err [NUM_CH];
  longint     m_stats [NUM_CH];
  int         obs_words [NUM_CH];
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      bq[c].delete();
      pend[c]    = 0;
      cur[c]     = 0;
      left[c]    = 0;
      m_err[c]   = '0;
      m_stats[c] = 0;
    end
  endtask

  task automatic model_step();
    for (int c = 0; c < NUM_CH; c++) begin
      bit beat, ack, do_pop;
      int bc, old_size, head, p;
      beat     = bus.kernel_avmm_wr[c] && !bus.kernel_avmm_waitreq[c];
      ack      = bus.burst_ack[c];
      bc       = int'(bus.kernel_avmm_burstcnt[c*BW +: BW]);
      old_size = bq[c].size();
      if (cur[c] > 0 && m_stats[c] < 64'hFFFF_FFFF) m_stats[c]++;
      do_pop = (cur[c] <= 1) && (old_size > 0) && (pend[c] > 0 || ack);
      head = 0;
      if (do_pop) head = bq[c].pop_front();
      if (beat) begin
        if (left[c] == 0) begin
          if (bc == 0) m_err[c][ERR_ZERO_BC] = 1'b1;
          else begin
            if (old_size == DEPTH) m_err[c][ERR_OVF] = 1'b1;
            else bq[c].push_back(bc);
            left[c] = bc - 1;
          end
        end else begin
          left[c]--;
        end
      end
      if (do_pop) cur[c] = head;
      else if (cur[c] > 0) cur[c]--;
      p = pend[c] + int'(ack) - int'(do_pop);
      if (ack && p > bq[c].size()) begin
        m_err[c][ERR_UNEXP_ACK] = 1'b1;
        p = pend[c] - int'(do_pop);
      end
      pend[c] = p;
    end
  endtask

  task automatic check_outputs();
    for (int c = 0; c < NUM_CH; c++) begin
      logic [63:0] exp_stats;
`ifdef AVMM_WR_ACK_MC_STATS_EN
      exp_stats = m_stats[c];
`else
      exp_stats = 0;
`endif
      obs_words[c] += int'(bus.word_ack[c]);
      check($sformatf("word_ack[%0d]", c), bus.word_ack[c], cur[c] > 0);
      check($sformatf("outstanding[%0d]", c), bus.outstanding_bursts[c*CNT_W +: CNT_W], bq[c].size());
      check($sformatf("wr_stall[%0d]", c), bus.wr_stall[c], bq[c].size() == DEPTH);
      check($sformatf("err_flags[%0d]", c), bus.err_flags[c*3 +: 3], m_err[c]);
      check($sformatf("stats_words[%0d]", c), bus.stats_words[c*32 +: 32], exp_stats);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.kernel_avmm_wr       = '0;
    bus.kernel_avmm_waitreq  = '0;
    bus.kernel_avmm_burstcnt = '0;
    bus.burst_ack            = '0;
  endtask

  task automatic idle(input int n);
    idle_inputs();
    repeat (n) tick();
  endtask

  task automatic send_burst(input int c, input int n);
    for (int i = 0; i < n; i++) begin
      idle_inputs();
      bus.kernel_avmm_wr[c]             = 1'b1;
      bus.kernel_avmm_burstcnt[c*BW +: BW] = BW'(n);
      tick();
    end
    idle_inputs();
  endtask

  task automatic pulse_ack(input int c);
    idle_inputs();
    bus.burst_ack[c] = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_word_ack"}, bus.word_ack, 0);
    check({tag, "_stall"}, bus.wr_stall, 0);
    check({tag, "_outstanding"}, bus.outstanding_bursts, 0);
    check({tag, "_err"}, bus.err_flags, 0);
    check({tag, "_stats_lo"}, bus.stats_words[63:0], 0);
    check({tag, "_stats_hi"}, bus.stats_words[127:64], 0);
  endtask

  task automatic apply_reset(input string tag);
    rst = 1'b1;
    #1;
    reset_checks(tag);
    model_reset();
    idle_inputs();
    repeat (2) tick();
    rst = 1'b0;
    idle(3);
  endtask

  initial begin
    int w;
    rst = 1'b1;
    idle_inputs();
    model_reset();
    for (int c = 0; c < NUM_CH; c++) obs_words[c] = 0;
    repeat (3) @(posedge clk);
    #1;
    reset_checks("reset");
    rst = 1'b0;
    idle(3);

    // single burst of 4 on ch0
    w = obs_words[0];
    send_burst(0, 4);
    idle(3);
    check("single_outstanding", bus.outstanding_bursts[0 +: CNT_W], 1);
    pulse_ack(0);
    check("single_first_word", bus.word_ack[0], 1);
    check("single_popped", bus.outstanding_bursts[0 +: CNT_W], 0);
    idle(6);
    check("single_words", obs_words[0] - w, 4);

    // back-to-back 3 + 5 on ch1
    w = obs_words[1];
    send_burst(1, 3);
    send_burst(1, 5);
    pulse_ack(1);
    pulse_ack(1);
    idle(10);
    check("b2b_words", obs_words[1] - w, 8);
    check("b2b_err", bus.err_flags[3 +: 3], 0);

    // fill and overflow ch2
    w = obs_words[2];
    repeat (4) send_burst(2, 1);
    idle(1);
    check("full_stall", bus.wr_stall[2], 1);
    send_burst(2, 1);
    idle(1);
    check("ovf_err", bus.err_flags[6 + ERR_OVF], 1);
    check("ovf_count", bus.outstanding_bursts[2*CNT_W +: CNT_W], DEPTH);
    repeat (4) pulse_ack(2);
    idle(6);
    check("ovf_words", obs_words[2] - w, 4);

    // unexpected ack, then same-cycle enqueue and ack on ch3
    w = obs_words[3];
    pulse_ack(3);
    idle(2);
    check("unexp_err", bus.err_flags[9 +: 3], 3'b010);
    check("unexp_words", obs_words[3] - w, 0);
    idle_inputs();
    bus.kernel_avmm_wr[3]          = 1'b1;
    bus.kernel_avmm_burstcnt[21 +: BW] = BW'(2);
    bus.burst_ack[3]               = 1'b1;
    tick();
    idle_inputs();
    bus.kernel_avmm_wr[3]          = 1'b1;
    bus.kernel_avmm_burstcnt[21 +: BW] = BW'(2);
    tick();
    idle(6);
    check("same_cycle_words", obs_words[3] - w, 2);
    check("same_cycle_err", bus.err_flags[9 +: 3], 3'b010);

    // randomized traffic on all channels
    apply_reset("rand_rst");
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        bus.kernel_avmm_wr[c]      = $urandom_range(0, 1) == 1;
        bus.kernel_avmm_waitreq[c] = ($urandom_range(0, 3) == 0) ||
                                     (bus.wr_stall[c] && $urandom_range(0, 1) == 1);
        bus.kernel_avmm_burstcnt[c*BW +: BW] =
          ($urandom_range(0, 15) == 0) ? BW'(0) : BW'($urandom_range(1, 6));
        bus.burst_ack[c]           = $urandom_range(0, 3) == 0;
      end
      tick();
    end
    idle(40);

    // reset during the third word of a 6-word expansion
    apply_reset("pre_mid_rst");
    w = obs_words[0];
    send_burst(0, 6);
    pulse_ack(0);
    tick();
    tick();
    check("mid_third_word", bus.word_ack[0], 1);
    apply_reset("mid_rst");
    w = obs_words[0];
    send_burst(0, 3);
    pulse_ack(0);
    idle(5);
    check("post_rst_words", obs_words[0] - w, 3);

    // 100 words per channel
    apply_reset("stats_rst");
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 25; i++) begin
        idle_inputs();
        bus.kernel_avmm_wr = '1;
        for (int c = 0; c < NUM_CH; c++) bus.kernel_avmm_burstcnt[c*BW +: BW] = BW'(25);
        tick();
      end
    end
    for (int c = 0; c < NUM_CH; c++) obs_words[c] = 0;
    for (int b = 0; b < 4; b++) begin
      idle_inputs();
      bus.burst_ack = '1;
      tick();
    end
    idle(110);
    for (int c = 0; c < NUM_CH; c++) begin
      check($sformatf("stats_obs_words[%0d]", c), obs_words[c], 100);
`ifdef AVMM_WR_ACK_MC_STATS_EN
      check($sformatf("stats_total[%0d]", c), bus.stats_words[c*32 +: 32], 100);
`else
      check($sformatf("stats_total[%0d]", c), bus.stats_words[c*32 +: 32], 0);
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
